// File: rtl/fir_mac_if.sv
// Sample, coefficient and result signals between a channel-strip source and
// the FIR MAC engine.
interface fir_mac_if #(
  parameter int L = 5
);
  localparam int AW = (L > 1) ? $clog2(L) : 1;

  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_data;
  logic          coef_we;
  logic [AW-1:0] coef_addr;
  logic [15:0]   coef_data;
  logic          busy;
  logic          out_valid;
  logic [15:0]   out_data;

  modport master (
    output in_valid, in_data, coef_we, coef_addr, coef_data,
    input  in_ready, busy, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, coef_we, coef_addr, coef_data,
    output in_ready, busy, out_valid, out_data
  );
endinterface

// File: rtl/fir_mac_engine.sv
// Serial L-tap FIR: circular sample history, one signed MAC per clock,
// rounded and saturated Q1.15 output pulse per accepted sample.
module fir_mac_engine #(
  parameter int L     = 5,
  parameter int ACC_W = 40
) (
  input  logic      i_clk,
  input  logic      i_reset,
  fir_mac_if.slave  bus
);
  localparam int AW = (L > 1) ? $clog2(L) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                    r_state;
  logic signed [15:0]        r_buf  [L];
  logic signed [15:0]        r_coef [L];
  logic [AW-1:0]             r_wr_ptr;
  logic [AW-1:0]             r_rd_ptr;
  logic [AW-1:0]             r_k;
  logic signed [ACC_W-1:0]   r_acc;
  logic                      r_in_ready;
  logic                      r_busy;
  logic                      r_out_valid;
  logic [15:0]               r_out_data;

  logic signed [31:0]        w_prod;
  logic signed [ACC_W-1:0]   w_prod_ext;
  logic signed [ACC_W-1:0]   w_rnd;
  logic signed [ACC_W-1:0]   w_shift;
  logic                      w_addr_ok;

  function automatic logic [15:0] sat16(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] max_v;
    logic signed [ACC_W-1:0] min_v;
    max_v = {{(ACC_W-16){1'b0}}, 16'h7FFF};
    min_v = {{(ACC_W-16){1'b1}}, 16'h8000};
    if (v > max_v) begin
      return 16'h7FFF;
    end else if (v < min_v) begin
      return 16'h8000;
    end else begin
      return v[15:0];
    end
  endfunction

  // r_rd_ptr walks backwards from the newest sample while r_k walks the taps forwards
  always_comb begin
    w_prod     = r_buf[r_rd_ptr] * r_coef[r_k];
    w_prod_ext = {{(ACC_W-32){w_prod[31]}}, w_prod};
    w_rnd      = r_acc + {{(ACC_W-15){1'b0}}, 15'h4000};
    w_shift    = w_rnd >>> 15;
    w_addr_ok  = ({{(32-AW){1'b0}}, bus.coef_addr} < 32'(L));
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_k         <= '0;
      r_acc       <= '0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= 16'h0000;
      for (int i = 0; i < L; i++) begin
        r_buf[i]  <= 16'sh0000;
        r_coef[i] <= (i == 0) ? 16'sh7FFF : 16'sh0000;
      end
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // coefficient write lands on the same edge as the accept, so it is used for this sample
          if (bus.coef_we && w_addr_ok) begin
            r_coef[bus.coef_addr] <= bus.coef_data;
          end
          if (bus.in_valid && r_in_ready) begin
            r_buf[r_wr_ptr] <= bus.in_data;
            r_rd_ptr        <= r_wr_ptr;
            r_wr_ptr        <= (r_wr_ptr == AW'(L-1)) ? '0 : r_wr_ptr + AW'(1);
            r_acc           <= '0;
            r_k             <= '0;
            r_in_ready      <= 1'b0;
            r_busy          <= 1'b1;
            r_state         <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          r_acc    <= r_acc + w_prod_ext;
          r_k      <= r_k + AW'(1);
          r_rd_ptr <= (r_rd_ptr == '0) ? AW'(L-1) : r_rd_ptr - AW'(1);
          if (r_k == AW'(L-1)) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_out_data  <= sat16(w_shift);
          r_out_valid <= 1'b1;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_in_ready <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.busy      = r_busy;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
endmodule
